// File: rtl/cmp_pkg.sv
// Shared types and constants for the arbitrated five-flag comparator.
package cmp_pkg;

    localparam int LEN_DEFAULT = 16;

    // Bit positions of each flag inside flags_t
    localparam int FLAG_EQ = 0;
    localparam int FLAG_SG = 1;
    localparam int FLAG_UG = 2;
    localparam int FLAG_MG = 3;
    localparam int FLAG_XG = 4;

    // Packed so that bit FLAG_x of the vector is field x
    typedef struct packed {
        logic xg;
        logic mg;
        logic ug;
        logic sg;
        logic eq;
    } flags_t;

endpackage

// File: rtl/cmp_core.sv
// Combinational five-flag comparator: equality plus four flavours of "greater than".
module cmp_core
    import cmp_pkg::*;
#(
    parameter int LEN = LEN_DEFAULT
) (
    input  logic [LEN-1:0] a,
    input  logic [LEN-1:0] b,
    output flags_t         flags
);

    logic signed [LEN-1:0] a_s;
    logic signed [LEN-1:0] b_s;

    assign a_s = a;
    assign b_s = b;

    // Mixing a signed and an unsigned operand makes the whole compare unsigned,
    // so mg and xg always agree with ug.
    always_comb begin
        flags    = '0;
        flags.eq = (a == b);
        flags.sg = (a_s > b_s);
        flags.ug = (a > b);
        flags.mg = ($signed(a) > $unsigned(b));
        flags.xg = ($unsigned(a) > $signed(b));
    end

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one cmp_core among NREQ requesters through a
// two-stage pipeline (operand register S1, result register S2) with a
// valid/ready result port.
module cmp_arbiter
    import cmp_pkg::*;
#(
    parameter int LEN  = LEN_DEFAULT,
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [NREQ-1:0]     REQ,
    input  logic [NREQ*LEN-1:0] OPA,
    input  logic [NREQ*LEN-1:0] OPB,
    output logic [NREQ-1:0]     GNT,
    output logic                RES_VLD,
    input  logic                RES_RDY,
    output logic [IDW-1:0]      RES_ID,
    output logic                RES_EQ,
    output logic                RES_SG,
    output logic                RES_UG,
    output logic                RES_MG,
    output logic                RES_XG
);

    // Stage 1: captured operands of the winning requester
    logic [LEN-1:0]  s1_a;
    logic [LEN-1:0]  s1_b;
    logic [IDW-1:0]  s1_id;
    logic            s1_v;

    // Stage 2: registered compare result
    flags_t          res_flags;
    logic [IDW-1:0]  res_id;
    logic            res_vld;

    logic [IDW-1:0]  ptr;
    logic            s2_adv;
    logic            accept;
    logic            any_gnt;
    logic [IDW-1:0]  win_id;
    logic [NREQ-1:0] gnt_vec;
    flags_t          core_flags;

    // Pointer to the requester after the winner, wrapping at NREQ-1
    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] w);
        if (int'(w) >= NREQ - 1)
            return '0;
        else
            return w + IDW'(1);
    endfunction

    assign s2_adv = s1_v && (!res_vld || RES_RDY);
    assign accept = !s1_v || s2_adv;

    // Round-robin search starting at ptr; no grant while in reset or S1 cannot take new operands
    always_comb begin
        int idx;
        gnt_vec = '0;
        win_id  = '0;
        any_gnt = 1'b0;
        idx     = 0;
        if (RST_N && accept) begin
            for (int i = 0; i < NREQ; i++) begin
                idx = int'(ptr) + i;
                if (idx >= NREQ)
                    idx = idx - NREQ;
                if (!any_gnt && REQ[idx]) begin
                    any_gnt      = 1'b1;
                    win_id       = IDW'(idx);
                    gnt_vec[idx] = 1'b1;
                end
            end
        end
    end

    assign GNT = gnt_vec;

    // S1 operand capture from the granted requester; later operand changes are ignored
    always_ff @(posedge CLK) begin
        if (any_gnt) begin
            s1_a  <= OPA[int'(win_id)*LEN +: LEN];
            s1_b  <= OPB[int'(win_id)*LEN +: LEN];
            s1_id <= win_id;
        end
    end

    // S1 valid and round-robin pointer
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_v <= 1'b0;
            ptr  <= '0;
        end else if (any_gnt) begin
            s1_v <= 1'b1;
            ptr  <= next_ptr(win_id);
        end else if (s2_adv) begin
            s1_v <= 1'b0;
        end
    end

    cmp_core #(
        .LEN (LEN)
    ) u_core (
        .a     (s1_a),
        .b     (s1_b),
        .flags (core_flags)
    );

    // S2 result register; held stable while the consumer stalls
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            res_vld   <= 1'b0;
            res_id    <= '0;
            res_flags <= '0;
        end else if (s2_adv) begin
            res_vld   <= 1'b1;
            res_id    <= s1_id;
            res_flags <= core_flags;
        end else if (RES_RDY) begin
            res_vld   <= 1'b0;
        end
    end

    assign RES_VLD = res_vld;
    assign RES_ID  = res_id;
    assign RES_EQ  = res_flags.eq;
    assign RES_SG  = res_flags.sg;
    assign RES_UG  = res_flags.ug;
    assign RES_MG  = res_flags.mg;
    assign RES_XG  = res_flags.xg;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed bench for cmp_arbiter (LEN=16, NREQ=4).
module tb_cmp_arbiter;

    logic        CLK;
    logic        RST_N;
    logic [3:0]  REQ;
    logic [63:0] OPA;
    logic [63:0] OPB;
    logic [3:0]  GNT;
    logic        RES_VLD;
    logic        RES_RDY;
    logic [1:0]  RES_ID;
    logic        RES_EQ;
    logic        RES_SG;
    logic        RES_UG;
    logic        RES_MG;
    logic        RES_XG;

    int checks = 0;
    int errors = 0;

    cmp_arbiter #(
        .LEN  (16),
        .NREQ (4)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .REQ     (REQ),
        .OPA     (OPA),
        .OPB     (OPB),
        .GNT     (GNT),
        .RES_VLD (RES_VLD),
        .RES_RDY (RES_RDY),
        .RES_ID  (RES_ID),
        .RES_EQ  (RES_EQ),
        .RES_SG  (RES_SG),
        .RES_UG  (RES_UG),
        .RES_MG  (RES_MG),
        .RES_XG  (RES_XG)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        OPA[i*16 +: 16] = a;
        OPB[i*16 +: 16] = b;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        REQ   = '0;
        step();
        RST_N = 1'b1;
    endtask

    // {XG, MG, UG, SG, EQ}
    function automatic logic [31:0] flg();
        return 32'({RES_XG, RES_MG, RES_UG, RES_SG, RES_EQ});
    endfunction

    logic [31:0] t2_flags [4];

    initial begin
        RST_N   = 1'b0;
        REQ     = 4'hF;
        RES_RDY = 1'b1;
        OPA     = '0;
        OPB     = '0;
        step();
        step();
        #1;
        chk("rst_gnt", 32'(GNT), 32'h0);
        chk("rst_vld", 32'(RES_VLD), 32'h0);
        chk("rst_id", 32'(RES_ID), 32'h0);
        chk("rst_flags", flg(), 32'h0);

        // 1: single requester, 0x8000 vs 0x0001
        RST_N = 1'b1;
        REQ   = 4'b0001;
        set_op(0, 16'h8000, 16'h0001);
        #1;
        chk("t1_gnt_c0", 32'(GNT), 32'h1);
        step();
        REQ = '0;
        #1;
        chk("t1_vld_c1", 32'(RES_VLD), 32'h0);
        chk("t1_gnt_c1", 32'(GNT), 32'h0);
        step();
        chk("t1_vld_c2", 32'(RES_VLD), 32'h1);
        chk("t1_id", 32'(RES_ID), 32'h0);
        chk("t1_flags", flg(), 32'h1C);
        step();
        chk("t1_vld_c3", 32'(RES_VLD), 32'h0);

        // 2: all four requesting, back-to-back round robin
        do_reset();
        set_op(0, 16'h0000, 16'h0002);
        set_op(1, 16'h0005, 16'h0005);
        set_op(2, 16'hFFFE, 16'h0003);
        set_op(3, 16'h0003, 16'hFFFE);
        t2_flags[0] = 32'h00;
        t2_flags[1] = 32'h01;
        t2_flags[2] = 32'h1C;
        t2_flags[3] = 32'h02;
        REQ = 4'hF;
        for (int k = 0; k < 7; k++) begin
            if (k > 0)
                step();
            if (k == 6)
                REQ = '0;
            #1;
            if (k < 6)
                chk($sformatf("t2_gnt_c%0d", k), 32'(GNT), 32'(1 << (k % 4)));
            if (k >= 2) begin
                chk($sformatf("t2_vld_c%0d", k), 32'(RES_VLD), 32'h1);
                chk($sformatf("t2_id_c%0d", k), 32'(RES_ID), 32'((k - 2) % 4));
                chk($sformatf("t2_flags_c%0d", k), flg(), t2_flags[(k - 2) % 4]);
            end
        end
        step();
        chk("t2_tail_id", 32'(RES_ID), 32'h1);
        chk("t2_tail_vld", 32'(RES_VLD), 32'h1);
        step();
        chk("t2_drain_vld", 32'(RES_VLD), 32'h0);

        // 3/4: stall with full pipe, then release
        do_reset();
        RES_RDY = 1'b0;
        set_op(0, 16'hFFFF, 16'hFFFF);
        set_op(1, 16'h0005, 16'h0005);
        set_op(2, 16'h0001, 16'hFFFF);
        REQ = 4'b0110;
        #1;
        chk("t3_gnt_c0", 32'(GNT), 32'h2);
        step();
        REQ = 4'b0100;
        #1;
        chk("t3_gnt_c1", 32'(GNT), 32'h4);
        chk("t3_vld_c1", 32'(RES_VLD), 32'h0);
        step();
        REQ = 4'b0001;
        set_op(2, 16'hFFFF, 16'hFFFF);
        #1;
        for (int s = 0; s < 5; s++) begin
            if (s > 0)
                step();
            chk($sformatf("t3_stall_gnt_%0d", s), 32'(GNT), 32'h0);
            chk($sformatf("t3_stall_vld_%0d", s), 32'(RES_VLD), 32'h1);
            chk($sformatf("t3_stall_id_%0d", s), 32'(RES_ID), 32'h1);
            chk($sformatf("t3_stall_flags_%0d", s), flg(), 32'h01);
        end
        step();
        RES_RDY = 1'b1;
        #1;
        chk("t3_rel_gnt", 32'(GNT), 32'h1);
        chk("t3_rel_id", 32'(RES_ID), 32'h1);
        step();
        REQ = '0;
        #1;
        chk("t3_id2_vld", 32'(RES_VLD), 32'h1);
        chk("t3_id2", 32'(RES_ID), 32'h2);
        chk("t3_id2_flags", flg(), 32'h02);
        step();
        chk("t3_id0", 32'(RES_ID), 32'h0);
        chk("t3_id0_flags", flg(), 32'h01);
        step();
        chk("t3_drain_vld", 32'(RES_VLD), 32'h0);

        // 5: reset with S1 and S2 full
        RES_RDY = 1'b0;
        REQ = 4'b0011;
        #1;
        chk("t5_gnt_c0", 32'(GNT), 32'h2);
        step();
        REQ = 4'b0001;
        #1;
        chk("t5_gnt_c1", 32'(GNT), 32'h1);
        step();
        chk("t5_full_gnt", 32'(GNT), 32'h0);
        chk("t5_full_vld", 32'(RES_VLD), 32'h1);
        chk("t5_full_id", 32'(RES_ID), 32'h1);
        RST_N = 1'b0;
        #1;
        chk("t5_rst_gnt", 32'(GNT), 32'h0);
        step();
        RST_N   = 1'b1;
        RES_RDY = 1'b1;
        REQ     = 4'b1010;
        set_op(1, 16'h0000, 16'h0000);
        set_op(3, 16'h7FFF, 16'h8000);
        #1;
        chk("t5_post_vld", 32'(RES_VLD), 32'h0);
        chk("t5_post_id", 32'(RES_ID), 32'h0);
        chk("t5_post_flags", flg(), 32'h0);
        chk("t5_post_gnt", 32'(GNT), 32'h2);
        step();
        REQ = 4'b1000;
        #1;
        chk("t5_gnt3", 32'(GNT), 32'h8);
        chk("t5_stale_vld", 32'(RES_VLD), 32'h0);

        // 6: wrap after grant to 3, then back to 3
        step();
        REQ = 4'b1001;
        set_op(0, 16'h1234, 16'h1233);
        #1;
        chk("t6_wrap_gnt", 32'(GNT), 32'h1);
        chk("t6_id1", 32'(RES_ID), 32'h1);
        chk("t6_id1_flags", flg(), 32'h01);
        step();
        chk("t6_next_gnt", 32'(GNT), 32'h8);
        chk("t6_id3", 32'(RES_ID), 32'h3);
        chk("t6_id3_flags", flg(), 32'h02);
        step();
        REQ = '0;
        #1;
        chk("t6_id0", 32'(RES_ID), 32'h0);
        chk("t6_id0_flags", flg(), 32'h1E);
        step();
        chk("t6_id3b", 32'(RES_ID), 32'h3);
        chk("t6_id3b_vld", 32'(RES_VLD), 32'h1);
        step();
        chk("t6_drain_vld", 32'(RES_VLD), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
